comp_bin_extremos: RTL and testbench

- Stream stage that consumes N-bit samples framed by valid/last and reports the running maximum and minimum of each frame, their indices and the sample count.
- Uses the same ordering rule as the team's binary comparator: unsigned, or signed via offset binary (MSB inverted before an unsigned compare), selected by i_Ctrl.
- Sits downstream of the sample source. Results leave through a valid/ready output handshake to the frame consumer.

---
 rtl/comp_bin_extremos_if.sv | 34 +++
 rtl/comp_bin_extremos.sv | 133 +++++++++++++
 tb/tb_comp_bin_extremos.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/comp_bin_extremos_if.sv
// rtl/comp_bin_extremos_if.sv - sample stream in, frame extremes out, grouped for comp_bin_extremos
interface comp_bin_extremos_if #(
    parameter int N       = 8,
    parameter int MAX_LEN = 256,
    parameter int IDX_W   = $clog2(MAX_LEN)
);
    // Sample side
    logic             i_Ctrl;
    logic [N-1:0]     i_Dato;
    logic             i_Valido;
    logic             i_Ultimo;
    logic             o_Listo;
    // Result side
    logic [N-1:0]     o_Max;
    logic [N-1:0]     o_Min;
    logic [IDX_W-1:0] o_IdxMax;
    logic [IDX_W-1:0] o_IdxMin;
    logic [IDX_W:0]   o_Cuenta;
    logic             o_Desborde;
    logic             o_Valido;
    logic             i_Listo;

    // Environment: sample source and frame consumer
    modport master (
        output i_Ctrl, i_Dato, i_Valido, i_Ultimo, i_Listo,
        input  o_Listo, o_Max, o_Min, o_IdxMax, o_IdxMin, o_Cuenta, o_Desborde, o_Valido
    );

    // The extremes stage itself
    modport slave (
        input  i_Ctrl, i_Dato, i_Valido, i_Ultimo, i_Listo,
        output o_Listo, o_Max, o_Min, o_IdxMax, o_IdxMin, o_Cuenta, o_Desborde, o_Valido
    );
endinterface

// File: rtl/comp_bin_extremos.sv
// rtl/comp_bin_extremos.sv - per-frame running max/min with indices and count, unsigned or offset-binary signed
module comp_bin_extremos #(
    parameter int N       = 8,
    parameter int MAX_LEN = 256,
    parameter int IDX_W   = $clog2(MAX_LEN)
) (
    input logic               i_Clk,
    input logic               i_Rst_n,
    comp_bin_extremos_if.slave bus
);
    typedef enum logic [1:0] {REPOSO, ACUM, SALIDA} estado_t;

    localparam logic [IDX_W:0] IDX_FINAL = (IDX_W + 1)'(MAX_LEN - 1);

    estado_t          estado, estado_sig;
    logic             modo_q, modo_d;
    logic [N-1:0]     max_q, max_d, min_q, min_d;
    logic [IDX_W-1:0] idx_max_q, idx_max_d, idx_min_q, idx_min_d;
    logic [IDX_W:0]   cuenta_q, cuenta_d;
    logic             desb_q, desb_d;
    logic             valido_q, valido_d;
    logic             listo_q, listo_d;
    logic             acepta;
    logic [IDX_W-1:0] k;

    // Signed mode flips the MSB so a plain unsigned compare orders two's complement values
    function automatic logic [N-1:0] clave(input logic [N-1:0] d, input logic con_signo);
        return con_signo ? {~d[N-1], d[N-2:0]} : d;
    endfunction

    assign acepta = bus.i_Valido && listo_q;
    // While accumulating, the count so far equals the index of the incoming sample
    assign k      = cuenta_q[IDX_W-1:0];

    // Next state, running extremes and handshake flags; comparator works on the live sample
    always_comb begin
        estado_sig = estado;
        modo_d     = modo_q;
        max_d      = max_q;
        min_d      = min_q;
        idx_max_d  = idx_max_q;
        idx_min_d  = idx_min_q;
        cuenta_d   = cuenta_q;
        desb_d     = desb_q;
        valido_d   = valido_q;
        case (estado)
            REPOSO: begin
                if (acepta) begin
                    modo_d    = bus.i_Ctrl;
                    max_d     = bus.i_Dato;
                    min_d     = bus.i_Dato;
                    idx_max_d = '0;
                    idx_min_d = '0;
                    cuenta_d  = (IDX_W + 1)'(1);
                    desb_d    = 1'b0;
                    if (bus.i_Ultimo) begin
                        estado_sig = SALIDA;
                        valido_d   = 1'b1;
                    end else begin
                        estado_sig = ACUM;
                    end
                end
            end
            ACUM: begin
                if (acepta) begin
                    if (clave(bus.i_Dato, modo_q) > clave(max_q, modo_q)) begin
                        max_d     = bus.i_Dato;
                        idx_max_d = k;
                    end
                    if (clave(bus.i_Dato, modo_q) < clave(min_q, modo_q)) begin
                        min_d     = bus.i_Dato;
                        idx_min_d = k;
                    end
                    cuenta_d = cuenta_q + 1'b1;
                    if (bus.i_Ultimo) begin
                        estado_sig = SALIDA;
                        valido_d   = 1'b1;
                    end else if (cuenta_q == IDX_FINAL) begin
                        // Frame hit the length limit without a last marker
                        estado_sig = SALIDA;
                        valido_d   = 1'b1;
                        desb_d     = 1'b1;
                    end
                end
            end
            SALIDA: begin
                if (valido_q && bus.i_Listo) begin
                    estado_sig = REPOSO;
                    valido_d   = 1'b0;
                    desb_d     = 1'b0;
                end
            end
            default: estado_sig = REPOSO;
        endcase
        listo_d = (estado_sig != SALIDA);
    end

    // State and result registers; reset clears everything including the ready flag
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            estado    <= REPOSO;
            modo_q    <= 1'b0;
            max_q     <= '0;
            min_q     <= '0;
            idx_max_q <= '0;
            idx_min_q <= '0;
            cuenta_q  <= '0;
            desb_q    <= 1'b0;
            valido_q  <= 1'b0;
            listo_q   <= 1'b0;
        end else begin
            estado    <= estado_sig;
            modo_q    <= modo_d;
            max_q     <= max_d;
            min_q     <= min_d;
            idx_max_q <= idx_max_d;
            idx_min_q <= idx_min_d;
            cuenta_q  <= cuenta_d;
            desb_q    <= desb_d;
            valido_q  <= valido_d;
            listo_q   <= listo_d;
        end
    end

    assign bus.o_Listo    = listo_q;
    assign bus.o_Max      = max_q;
    assign bus.o_Min      = min_q;
    assign bus.o_IdxMax   = idx_max_q;
    assign bus.o_IdxMin   = idx_min_q;
    assign bus.o_Cuenta   = cuenta_q;
    assign bus.o_Desborde = desb_q;
    assign bus.o_Valido   = valido_q;
endmodule

// File: tb/tb_comp_bin_extremos.sv
// tb/tb_comp_bin_extremos.sv - randomized and directed bench for comp_bin_extremos with a scan-based reference
module tb_comp_bin_extremos;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   sel = 0;

    logic       v_ctrl = 1'b0;
    logic [7:0] v_dato = '0;
    logic       v_valido = 1'b0;
    logic       v_ultimo = 1'b0;
    logic       v_rdy = 1'b0;

    logic [7:0] frame_q[$];

    comp_bin_extremos_if #(.N(8), .MAX_LEN(256)) bus_a ();
    comp_bin_extremos_if #(.N(8), .MAX_LEN(4))   bus_b ();

    assign bus_a.i_Ctrl   = v_ctrl;
    assign bus_a.i_Dato   = v_dato;
    assign bus_a.i_Ultimo = v_ultimo;
    assign bus_a.i_Valido = v_valido && (sel == 0);
    assign bus_a.i_Listo  = v_rdy && (sel == 0);
    assign bus_b.i_Ctrl   = v_ctrl;
    assign bus_b.i_Dato   = v_dato;
    assign bus_b.i_Ultimo = v_ultimo;
    assign bus_b.i_Valido = v_valido && (sel == 1);
    assign bus_b.i_Listo  = v_rdy && (sel == 1);

    comp_bin_extremos #(.N(8), .MAX_LEN(256)) dut_a (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus_a));
    comp_bin_extremos #(.N(8), .MAX_LEN(4))   dut_b (.i_Clk(clk), .i_Rst_n(rst_n), .bus(bus_b));

    logic       m_listo, m_valido, m_desb;
    logic [7:0] m_max, m_min, m_imax, m_imin;
    logic [8:0] m_cnt;

    always_comb begin
        if (sel == 0) begin
            m_listo = bus_a.o_Listo;  m_valido = bus_a.o_Valido; m_desb = bus_a.o_Desborde;
            m_max   = bus_a.o_Max;    m_min    = bus_a.o_Min;
            m_imax  = bus_a.o_IdxMax; m_imin   = bus_a.o_IdxMin; m_cnt = bus_a.o_Cuenta;
        end else begin
            m_listo = bus_b.o_Listo;  m_valido = bus_b.o_Valido; m_desb = bus_b.o_Desborde;
            m_max   = bus_b.o_Max;    m_min    = bus_b.o_Min;
            m_imax  = {6'b0, bus_b.o_IdxMax}; m_imin = {6'b0, bus_b.o_IdxMin};
            m_cnt   = {6'b0, bus_b.o_Cuenta};
        end
    end

    // Offer every sample of frame_q, waiting (bounded) for the stage to take each one
    task automatic push_samples(input logic ctrl, input bit toggle, input bit with_last);
        int n;
        for (int i = 0; i < frame_q.size(); i++) begin
            v_dato   = frame_q[i];
            v_valido = 1'b1;
            v_ultimo = with_last && (i == frame_q.size() - 1);
            v_ctrl   = (toggle && i > 0) ? ~ctrl : ctrl;
            n = 0;
            while (m_listo !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (m_listo !== 1'b1) begin
                errors++;
                $display("FAIL accept_timeout sel=%0d sample=%0d: o_Listo=%b required 1", sel, i, m_listo);
            end
            if (i == frame_q.size() - 1) begin
                checks++;
                if (m_valido !== 1'b0) begin
                    errors++;
                    $display("FAIL valid_early sel=%0d: o_Valido=%b required 0", sel, m_valido);
                end
            end
            @(negedge clk);
        end
        v_valido = 1'b0;
        v_ultimo = 1'b0;
    endtask

    // Reference: plain integer scan of the frame, first occurrence wins; then hold and handshake
    task automatic check_result(input logic ctrl, input bit desb_exp, input int hold, input bit hold_valid);
        logic [7:0] emx, emn;
        int eimx, eimn, v, hi, lo;
        logic [8:0] ecnt;
        emx = '0; emn = '0; eimx = 0; eimn = 0; hi = 0; lo = 0;
        for (int i = 0; i < frame_q.size(); i++) begin
            v = ctrl ? int'($signed(frame_q[i])) : int'(frame_q[i]);
            if (i == 0 || v > hi) begin hi = v; eimx = i; emx = frame_q[i]; end
            if (i == 0 || v < lo) begin lo = v; eimn = i; emn = frame_q[i]; end
        end
        ecnt = 9'(frame_q.size());
        checks++;
        if (m_valido !== 1'b1) begin errors++; $display("FAIL valid_latency sel=%0d: o_Valido=%b required 1", sel, m_valido); end
        checks++;
        if (m_max !== emx) begin errors++; $display("FAIL max sel=%0d: got %0h required %0h", sel, m_max, emx); end
        checks++;
        if (m_min !== emn) begin errors++; $display("FAIL min sel=%0d: got %0h required %0h", sel, m_min, emn); end
        checks++;
        if (m_imax !== 8'(eimx)) begin errors++; $display("FAIL idx_max sel=%0d: got %0d required %0d", sel, m_imax, eimx); end
        checks++;
        if (m_imin !== 8'(eimn)) begin errors++; $display("FAIL idx_min sel=%0d: got %0d required %0d", sel, m_imin, eimn); end
        checks++;
        if (m_cnt !== ecnt) begin errors++; $display("FAIL count sel=%0d: got %0d required %0d", sel, m_cnt, ecnt); end
        checks++;
        if (m_desb !== desb_exp) begin errors++; $display("FAIL overflow sel=%0d: got %b required %b", sel, m_desb, desb_exp); end
        v_valido = hold_valid;
        v_dato   = 8'hEE;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (m_valido !== 1'b1 || m_listo !== 1'b0 || m_max !== emx || m_min !== emn || m_cnt !== ecnt) begin
                errors++;
                $display("FAIL hold sel=%0d cycle=%0d: valid=%b ready=%b max=%0h min=%0h cnt=%0d required 1 0 %0h %0h %0d",
                         sel, h, m_valido, m_listo, m_max, m_min, m_cnt, emx, emn, ecnt);
            end
        end
        v_rdy = 1'b1;
        @(negedge clk);
        v_rdy    = 1'b0;
        v_valido = 1'b0;
        checks++;
        if (m_valido !== 1'b0 || m_listo !== 1'b1 || m_desb !== 1'b0) begin
            errors++;
            $display("FAIL handshake sel=%0d: valid=%b ready=%b overflow=%b required 0 1 0", sel, m_valido, m_listo, m_desb);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            checks++;
            if (m_listo !== 0 || m_valido !== 0 || m_desb !== 0 || m_max !== 0 || m_min !== 0 ||
                m_imax !== 0 || m_imin !== 0 || m_cnt !== 0) begin
                errors++;
                $display("FAIL reset_outputs sel=%0d: ready=%b valid=%b max=%0h min=%0h cnt=%0d required all 0",
                         s, m_listo, m_valido, m_max, m_min, m_cnt);
            end
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (m_listo !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b required 0", m_listo); end
        @(negedge clk);
        checks++;
        if (m_listo !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %b required 1", m_listo); end
    endtask

    task automatic test_unsigned();
        sel = 0;
        frame_q = '{8'h10, 8'h80, 8'h05, 8'h80};
        push_samples(1'b0, 1'b0, 1'b1);
        check_result(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_signed_toggle();
        sel = 0;
        frame_q = '{8'h10, 8'h80, 8'h05, 8'h80};
        push_samples(1'b1, 1'b1, 1'b1);
        check_result(1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_single();
        sel = 0;
        frame_q = '{8'h7F};
        push_samples(1'b0, 1'b0, 1'b1);
        check_result(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        sel = 0;
        frame_q = '{8'h33, 8'hC4, 8'h33};
        push_samples(1'b1, 1'b0, 1'b1);
        check_result(1'b1, 1'b0, 5, 1'b1);
        frame_q = '{8'h01, 8'h02};
        push_samples(1'b0, 1'b0, 1'b1);
        check_result(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_overflow();
        sel = 1;
        frame_q = '{8'd1, 8'd2, 8'd3, 8'd4};
        push_samples(1'b0, 1'b0, 1'b0);
        check_result(1'b0, 1'b1, 2, 1'b1);
        frame_q = '{8'd5, 8'd6, 8'd7};
        push_samples(1'b0, 1'b0, 1'b1);
        check_result(1'b0, 1'b0, 0, 1'b0);
        frame_q = '{8'd9, 8'd3, 8'd9, 8'd1};
        push_samples(1'b0, 1'b0, 1'b1);
        check_result(1'b0, 1'b0, 0, 1'b0);
        sel = 0;
    endtask

    task automatic test_reset_mid_frame();
        sel = 0;
        frame_q = '{8'h55, 8'h66};
        push_samples(1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_listo !== 0 || m_valido !== 0 || m_max !== 0 || m_min !== 0 || m_cnt !== 0 || m_imax !== 0) begin
            errors++;
            $display("FAIL async_reset: ready=%b valid=%b max=%0h min=%0h cnt=%0d required all 0",
                     m_listo, m_valido, m_max, m_min, m_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame_q = '{8'h22, 8'h11};
        push_samples(1'b0, 1'b0, 1'b1);
        check_result(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] pick[4];
        logic c;
        int len;
        pick = '{8'h00, 8'h7F, 8'h80, 8'hFF};
        for (int f = 0; f < 30; f++) begin
            sel = f % 2;
            len = (sel == 1) ? $urandom_range(1, 4) : $urandom_range(1, 12);
            frame_q.delete();
            for (int i = 0; i < len; i++)
                frame_q.push_back((f % 3 == 0) ? pick[$urandom_range(0, 3)] : 8'($urandom));
            c = 1'($urandom);
            push_samples(c, 1'($urandom), 1'b1);
            check_result(c, 1'b0, $urandom_range(0, 3), 1'($urandom));
        end
        sel = 0;
    endtask

    initial begin
        #12;
        test_reset();
        test_unsigned();
        test_signed_toggle();
        test_single();
        test_backpressure();
        test_overflow();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
